// File: rtl/hazard_perf_counter.sv
// Hazard/event statistics unit: cycle counter plus N_EVT saturating event
// counters with a run/pause/limit FSM, readable per channel or all at once.

module hpc_evt_chan #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      // an event that cannot be counted any more is recorded as overflow
      if (&cnt) ovf <= 1'b1;
      else      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

module hazard_perf_counter #(
  parameter int N_EVT = 2,
  parameter int CNT_W = 32,
  parameter int CYC_W = 32,
  parameter int SEL_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [CYC_W-1:0]       limit_i,
  input  logic [N_EVT-1:0]       evt_i,
  input  logic [N_EVT-1:0]       evt_en_i,
  input  logic [SEL_W-1:0]       rd_sel_i,
  output logic [CNT_W-1:0]       rd_cnt_o,
  output logic [N_EVT*CNT_W-1:0] cnt_flat_o,
  output logic [CYC_W-1:0]       cycle_o,
  output logic [N_EVT-1:0]       ovf_o,
  output logic                   running_o,
  output logic                   done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state;
  logic                          cnt_edge;
  logic [CYC_W-1:0]              cyc_nxt;
  logic [N_EVT-1:0]              inc;
  logic [N_EVT-1:0][CNT_W-1:0]   cnt;

  assign cnt_edge = (state == RUN) && start_i;
  // wraps to 0 once saturated, so a nonzero limit can never match there
  assign cyc_nxt  = cycle_o + CYC_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cycle_o <= '0;
    end else if (clear_i) begin
      state   <= IDLE;
      cycle_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) state <= RUN;
        RUN: begin
          if (!start_i) begin
            state <= IDLE;
          end else begin
            if (cycle_o != '1) cycle_o <= cyc_nxt;
            if (limit_i != '0 && cyc_nxt == limit_i) state <= DONE;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign running_o = (state == RUN);
  assign done_o    = (state == DONE);

  for (genvar k = 0; k < N_EVT; k++) begin : g_chan
    assign inc[k] = cnt_edge & evt_i[k] & evt_en_i[k];
    hpc_evt_chan #(.CNT_W(CNT_W)) u_chan (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr   (clear_i),
      .inc   (inc[k]),
      .cnt   (cnt[k]),
      .ovf   (ovf_o[k])
    );
  end

  assign cnt_flat_o = cnt;

  always_comb begin
    rd_cnt_o = '0;
    for (int k = 0; k < N_EVT; k++)
      if (rd_sel_i == SEL_W'(k)) rd_cnt_o = cnt[k];
  end
endmodule

// File: tb/tb_hazard_perf_counter.sv
// Scoreboard bench for hazard_perf_counter: driver pushes model results per
// edge, monitor pops and compares after each rising edge.

module tb_hazard_perf_counter;
  localparam int N  = 2;
  localparam int CW = 4;
  localparam int YW = 8;
  localparam int SW = 4;
  localparam int KMAX = (1 << CW) - 1;
  localparam int CMAX = (1 << YW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, clear;
  logic [YW-1:0]   limit;
  logic [N-1:0]    evt, en;
  logic [SW-1:0]   rd_sel;
  logic [CW-1:0]   rd_cnt;
  logic [N*CW-1:0] cnt_flat;
  logic [YW-1:0]   cycle;
  logic [N-1:0]    ovf;
  logic            running, done;

  hazard_perf_counter #(.N_EVT(N), .CNT_W(CW), .CYC_W(YW), .SEL_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .limit_i(limit), .evt_i(evt), .evt_en_i(en), .rd_sel_i(rd_sel),
    .rd_cnt_o(rd_cnt), .cnt_flat_o(cnt_flat), .cycle_o(cycle),
    .ovf_o(ovf), .running_o(running), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*CW-1:0] flat;
    logic [YW-1:0]   cyc;
    logic [N-1:0]    ovf;
    logic            run;
    logic            done;
    logic [CW-1:0]   rd;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // reference model: plain integers and flags
  int m_cnt[N];
  bit m_ovf[N];
  int m_cyc;
  bit m_run, m_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_cnt[k] = 0; m_ovf[k] = 0; end
    m_cyc = 0; m_run = 0; m_done = 0;
  endtask

  task automatic model_edge();
    if (clear) begin
      model_reset();
    end else if (m_done) begin
    end else if (!m_run) begin
      if (start) m_run = 1;
    end else if (!start) begin
      m_run = 0;
    end else begin
      if (int'(limit) != 0 && m_cyc + 1 == int'(limit)) begin m_done = 1; m_run = 0; end
      if (m_cyc < CMAX) m_cyc++;
      for (int k = 0; k < N; k++)
        if (evt[k] && en[k]) begin
          if (m_cnt[k] == KMAX) m_ovf[k] = 1;
          else m_cnt[k]++;
        end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.flat[k*CW +: CW] = CW'(m_cnt[k]);
      e.ovf[k] = m_ovf[k];
    end
    e.cyc  = YW'(m_cyc);
    e.run  = m_run;
    e.done = m_done;
    e.rd   = (int'(rd_sel) < N) ? CW'(m_cnt[rd_sel]) : '0;
    return e;
  endfunction

  // called at a negedge with inputs already set for the coming rising edge
  task automatic step();
    model_edge();
    q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic drive(input bit s, input bit c, input logic [N-1:0] e);
    start = s; clear = c; evt = e;
    step();
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("cnt_flat", 64'(cnt_flat), 64'(e.flat));
      check("cycle",    64'(cycle),    64'(e.cyc));
      check("ovf",      64'(ovf),      64'(e.ovf));
      check("running",  64'(running),  64'(e.run));
      check("done",     64'(done),     64'(e.done));
      check("rd_cnt",   64'(rd_cnt),   64'(e.rd));
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_cnt"},  64'(cnt_flat), 64'(0));
    check({tag, "_cyc"},  64'(cycle),    64'(0));
    check({tag, "_ovf"},  64'(ovf),      64'(0));
    check({tag, "_run"},  64'(running),  64'(0));
    check({tag, "_done"}, 64'(done),     64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 0; clear = 0; limit = '0; evt = '0; en = '1; rd_sel = '0;
    model_reset();
    #1 check_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // limit run: 30 counting edges, 5 ch0 and 3 ch1 strobes
    limit = YW'(30);
    drive(1, 0, 2'b00);
    for (int i = 0; i < 30; i++) drive(1, 0, {(i % 10 == 0), (i % 6 == 0)});
    check("lim_done", 64'(done), 64'(1));
    check("lim_cyc",  64'(cycle), 64'(30));
    check("lim_c0",   64'(cnt_flat[CW-1:0]), 64'(5));
    check("lim_c1",   64'(cnt_flat[2*CW-1:CW]), 64'(3));
    for (int i = 0; i < 5; i++) drive(1, 0, 2'b11);
    check("frozen_cyc", 64'(cycle), 64'(30));

    // pause/resume
    limit = '0;
    drive(1, 1, 2'b11);
    drive(1, 0, 2'b11);
    for (int i = 0; i < 10; i++) drive(1, 0, 2'b11);
    for (int i = 0; i < 4; i++)  drive(0, 0, 2'b11);
    for (int i = 0; i < 6; i++)  drive(1, 0, 2'b11);
    check("pause_cyc", 64'(cycle), 64'(15));
    check("pause_c",   64'(cnt_flat), 64'({4'd15, 4'd15}));

    // mask and readback
    en = 2'b01;
    drive(0, 1, 2'b00);
    drive(1, 0, 2'b11);
    for (int i = 0; i < 8; i++) drive(1, 0, 2'b11);
    rd_sel = 4'd0; drive(0, 0, 2'b11);
    check("rd0", 64'(rd_cnt), 64'(8));
    rd_sel = 4'd1; drive(0, 0, 2'b11);
    check("rd1", 64'(rd_cnt), 64'(0));
    rd_sel = 4'd5; drive(0, 0, 2'b11);
    check("rd5", 64'(rd_cnt), 64'(0));

    // saturation: 17 events on ch0
    en = 2'b11; rd_sel = 4'd0;
    drive(0, 1, 2'b00);
    drive(1, 0, 2'b00);
    for (int i = 0; i < 15; i++) drive(1, 0, 2'b01);
    check("pre_ovf", 64'(ovf), 64'(0));
    drive(1, 0, 2'b01);
    check("ovf16", 64'(ovf), 64'(2'b01));
    drive(1, 0, 2'b01);
    check("sat_c0", 64'(cnt_flat[CW-1:0]), 64'(15));

    // clear with simultaneous events while running
    drive(1, 1, 2'b11);
    check("clr_idle", 64'(running), 64'(0));
    drive(1, 0, 2'b11);
    check("clr_run", 64'(running), 64'(1));
    drive(1, 0, 2'b00);

    // async reset mid-run with cnt0 = 7
    drive(0, 1, 2'b00);
    drive(1, 0, 2'b00);
    for (int i = 0; i < 7; i++) drive(1, 0, 2'b01);
    start = 1; clear = 0; evt = '0;
    model_edge();
    q.push_back(model_out());
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_zero("async");
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    drive(1, 0, 2'b00);
    check("rerun", 64'(running), 64'(1));

    // cycle saturation with unlimited run
    drive(0, 1, 2'b00);
    for (int i = 0; i < 270; i++) begin
      rd_sel = SW'($urandom_range(0, 3));
      drive(1, 0, N'($urandom));
    end

    // random mix of start/clear/limit/mask/events
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) limit = ($urandom_range(0, 2) == 0) ? '0 : YW'($urandom_range(1, 40));
      en     = N'($urandom);
      rd_sel = SW'($urandom_range(0, 3));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, N'($urandom));
    end

    @(negedge clk);
    check("sb_drain", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
